dds_phase_segmenter: RTL

- Front end of the DDS polynomial path.
- Owns the phase accumulator and the frequency tuning word (FTW) load handshake.
- Splits the accumulated phase into a segment address (drives the coefficient ROM address of the polynomial evaluator) and a signed fixed-point in-segment argument x.
- Tracks evaluator pipeline latency so downstream logic gets an eval_valid aligned with the evaluated sample.

---
 rtl/dds_pkg.sv | 23 ++
 rtl/valid_delay_line.sv | 27 ++
 rtl/dds_phase_segmenter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared state type, default widths and LFSR constants for the DDS front end
package dds_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dds_state_e;

  localparam int DDS_DATA_WIDTH   = 16;
  localparam int DDS_ADDR_WIDTH   = 5;
  localparam int DDS_I_WIDTHX     = 2;
  localparam int DDS_PHASE_WIDTH  = 24;
  localparam int DDS_EVAL_LATENCY = 4;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - enable-gated valid shift register matching a fixed pipeline latency
module valid_delay_line #(
  parameter int LATENCY = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic valid_i,
  output logic valid_o
);

  logic [LATENCY-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q[0] <= valid_i;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign valid_o = stage_q[LATENCY-1];

endmodule

// File: rtl/dds_phase_segmenter.sv
// rtl/dds_phase_segmenter.sv - phase accumulator, FTW handshake and segment/argument split
// Optional sample dithering: define DDS_PHASE_DITHER_EN.
module dds_phase_segmenter
  import dds_pkg::*;
#(
  parameter int DATA_WIDTH   = DDS_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DDS_ADDR_WIDTH,
  parameter int I_widthX     = DDS_I_WIDTHX,
  parameter int PHASE_WIDTH  = DDS_PHASE_WIDTH,
  parameter int EVAL_LATENCY = DDS_EVAL_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   phase_clr,
  input  logic [PHASE_WIDTH-1:0] ftw_data,
  input  logic                   ftw_valid,
  output logic                   ftw_ready,
  output logic [ADDR_WIDTH-1:0]  address_ram_out,
  output logic [DATA_WIDTH-1:0]  x_argu_out,
  output logic                   sample_valid,
  output logic                   eval_valid,
  output logic                   running
);

  localparam int FRAC_W  = DATA_WIDTH - I_widthX;
  localparam int TOP_W   = ADDR_WIDTH + FRAC_W;

  dds_state_e             state_q;
  logic                   running_q;
  logic                   advance;
  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic [PHASE_WIDTH-1:0] ftw_active_q, ftw_active_d;
  logic [PHASE_WIDTH-1:0] ftw_shadow_q, ftw_shadow_d;
  logic                   pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  x_q, x_d;
  logic                   sv_q, sv_d;
  logic [TOP_W-1:0]       sample_top;

  // stop has priority over start; transitions ignore enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start && !stop) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: if (stop) begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign advance = enable && (state_q == RUN);

`ifdef DDS_PHASE_DITHER_EN
  localparam int DITHER_W = PHASE_WIDTH - TOP_W;
  logic [15:0]            lfsr_q;
  logic [PHASE_WIDTH-1:0] dither;
  logic [PHASE_WIDTH-1:0] dithered;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  // Only bits below the sampled window are dithered; a zero-width window masks to 0
  assign dither     = PHASE_WIDTH'(lfsr_q) & ~({PHASE_WIDTH{1'b1}} << DITHER_W);
  assign dithered   = acc_q + dither;
  assign sample_top = dithered[PHASE_WIDTH-1 -: TOP_W];
`else
  assign sample_top = acc_q[PHASE_WIDTH-1 -: TOP_W];
`endif

  always_comb begin
    acc_d        = acc_q;
    ftw_active_d = ftw_active_q;
    ftw_shadow_d = ftw_shadow_q;
    pending_d    = pending_q;
    addr_d       = addr_q;
    x_d          = x_q;
    sv_d         = sv_q;

    if (ftw_valid && !pending_q) begin
      ftw_shadow_d = ftw_data;
      pending_d    = 1'b1;
    end else if (pending_q && enable) begin
      ftw_active_d = ftw_shadow_q;
      pending_d    = 1'b0;
    end

    if (enable) begin
      if (phase_clr) begin
        acc_d = '0;
      end else if (state_q == RUN) begin
        acc_d = acc_q + ftw_active_q;
      end
      // Outputs take the pre-increment phase
      if (state_q == RUN) begin
        addr_d = sample_top[TOP_W-1 -: ADDR_WIDTH];
        x_d    = {{I_widthX{1'b0}}, sample_top[FRAC_W-1:0]};
        sv_d   = 1'b1;
      end else begin
        sv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      ftw_active_q <= '0;
      ftw_shadow_q <= '0;
      pending_q    <= 1'b0;
      addr_q       <= '0;
      x_q          <= '0;
      sv_q         <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      ftw_active_q <= ftw_active_d;
      ftw_shadow_q <= ftw_shadow_d;
      pending_q    <= pending_d;
      addr_q       <= addr_d;
      x_q          <= x_d;
      sv_q         <= sv_d;
    end
  end

  valid_delay_line #(
    .LATENCY (EVAL_LATENCY)
  ) u_valid_delay (
    .clk_i   (clk),
    .rst_ni  (rst),
    .en_i    (enable),
    .valid_i (sv_q),
    .valid_o (eval_valid)
  );

  assign ftw_ready       = ~pending_q;
  assign address_ram_out = addr_q;
  assign x_argu_out      = x_q;
  assign sample_valid    = sv_q;
  assign running         = running_q;

endmodule
